pe_filter_sequencer: RTL and testbench
======================================

// Module: pe_filter_sequencer
// PURPOSE
//  Control FSM directly upstream of the PE filter address generator. Drives its offset_cnt,
//  filter_size, en_filter and clear inputs so that every filter held in the filter spad is
//  convolved with the current ifmap window. Emits one psum per filter per window through a
//  valid/ready handshake, then requests a window slide.
// PARAMETERS
//  CONFIG_BIT   5  width of filter_size and offset_cnt (max filter length 2^CONFIG_BIT-1)
//  FNUM_BIT     4  width of num_filters and filter index
//  WNUM_BIT     8  width of num_windows and window index
// PORTS
//  clk          in   1          clock, rising edge
//  rstn         in   1          asynchronous active-low reset
//  start        in   1          pulse in IDLE: latch config and begin a job
//  cfg_fsize    in   CONFIG_BIT filter length in taps (1..2^CONFIG_BIT-1)
//  cfg_nfilt    in   FNUM_BIT   filters in spad (1..2^FNUM_BIT-1)
//  cfg_nwin     in   WNUM_BIT   windows to process (1..2^WNUM_BIT-1)
//  ifmap_valid  in   1          current ifmap window fully present in ifmap spad
//  psum_ready   in   1          downstream accepts psum this cycle
//  filter_size  out  CONFIG_BIT latched cfg_fsize, to address generator
//  offset_cnt   out  CONFIG_BIT tap index within filter, to address generator
//  en_filter    out  1          1-cycle pulse: advance filter base by filter_size
//  clear        out  1          1-cycle pulse: return filter base to 0
//  mac_en       out  1          MAC accumulates the tap addressed this cycle
//  psum_valid   out  1          psum available; held until psum_ready
//  psum_last    out  1          qualifies psum_valid: last filter of last window
//  win_advance  out  1          1-cycle pulse: ifmap spad slides window by stride
//  busy         out  1          high in every state except IDLE
//  cfg_err      out  1          1-cycle pulse: start rejected (a cfg field is zero)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched config and fidx/widx cleared.
//  States: IDLE, CLEAR, WAIT_WIN, MAC, EMIT, DONE.
//  IDLE: start with all cfg nonzero -> latch cfg, CLEAR. Start with any cfg zero -> cfg_err=1
//   next cycle, stay IDLE. start outside IDLE is ignored; cfg inputs are sampled only at start.
//  CLEAR: clear=1 for exactly one cycle, offset_cnt=0, fidx=0 -> WAIT_WIN.
//  WAIT_WIN: hold offset_cnt=0; ifmap_valid=1 -> MAC next cycle.
//  MAC: mac_en=1; offset_cnt = 0,1,..,fsize-1 on consecutive cycles (fsize cycles, no stall);
//   at offset fsize-1 -> EMIT. fsize=1 gives a single MAC cycle.
//  EMIT: psum_valid=1, mac_en=0, offset_cnt holds fsize-1. Stays until psum_valid&psum_ready.
//   On handshake:
//    fidx<nfilt-1  : en_filter=1 same cycle, fidx++, offset_cnt->0, -> MAC
//    fidx==nfilt-1, widx<nwin-1  : win_advance=1 and clear=1 same cycle, fidx=0, widx++, -> WAIT_WIN
//    fidx==nfilt-1, widx==nwin-1 : psum_last was 1 during this EMIT, -> DONE
//  DONE: busy=0 for one cycle, return to IDLE, counters cleared.
//  Latency: first psum_valid at (3 + fsize) cycles after start, given ifmap_valid already high.
//   Back-to-back filters with psum_ready=1: fsize+1 cycles per psum.
//  Counters wrap-free by construction: compare against latched cfg-1, never overflow.
//  Pulses (en_filter, clear, win_advance, cfg_err) never exceed one cycle and are never
//   asserted together except clear+win_advance at window boundaries.
//  ifmap_valid dropping in MAC/EMIT is ignored; window completeness is checked only in WAIT_WIN.
//  rstn asserted mid-job: immediate return to IDLE, all outputs 0; no psum is emitted.
// STRUCTURE
//  Shared header pe_ctrl_defs.vh: state encodings (3-bit localparams) and CONFIG_BIT default,
//   common with the address generators and the PE top.
//  One sub-module: bounded_counter (clear, inc, limit, last flag); instantiated three times
//   for offset, fidx and widx. FSM and output decode stay in this module.
// TESTING
//  fsize=3,nfilt=2,nwin=1, ifmap_valid=1, psum_ready=1 -> offset 0,1,2,en_filter,0,1,2, psum_last on 2nd psum, DONE.
//  fsize=1,nfilt=1,nwin=3 -> three psums, 2 win_advance+clear pulses, psum_last only on 3rd.
//  psum_ready low 5 cycles in EMIT -> psum_valid held 6 cycles, offset_cnt and fidx frozen.
//  ifmap_valid low 4 cycles after CLEAR -> stays WAIT_WIN, first mac_en 1 cycle after valid rises.
//  start with cfg_nfilt=0 -> cfg_err single pulse, busy stays 0; start during MAC ignored.
//  rstn low during MAC at offset 2 -> all outputs 0 asynchronously; new start runs cleanly.

Source files
------------

// File: rtl/pe_filter_sequencer_pkg.sv
// Shared widths, FSM state encoding and config helper for the PE filter sequencer.
package pe_filter_sequencer_pkg;

  // Width of filter_size/offset_cnt; max filter length is 2^ConfigBit-1 taps.
  localparam int unsigned ConfigBit = 5;
  // Width of num_filters and the filter index.
  localparam int unsigned FnumBit   = 4;
  // Width of num_windows and the window index.
  localparam int unsigned WnumBit   = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StWaitWin = 3'd2,
    StMac     = 3'd3,
    StEmit    = 3'd4,
    StDone    = 3'd5
  } state_e;

  // A job is only accepted when every config field is nonzero.
  function automatic logic cfg_valid(input logic [ConfigBit-1:0] fsize,
                                     input logic [FnumBit-1:0]   nfilt,
                                     input logic [WnumBit-1:0]   nwin);
    return (fsize != '0) && (nfilt != '0) && (nwin != '0);
  endfunction

endpackage

// File: rtl/pe_filter_sequencer_if.sv
// Control/handshake bundle between the filter sequencer and its environment.
interface pe_filter_sequencer_if;
  import pe_filter_sequencer_pkg::*;

  // Job control and configuration
  logic                 start;
  logic [ConfigBit-1:0] cfg_fsize;
  logic [FnumBit-1:0]   cfg_nfilt;
  logic [WnumBit-1:0]   cfg_nwin;
  logic                 ifmap_valid;
  logic                 psum_ready;

  // Address generator drive
  logic [ConfigBit-1:0] filter_size;
  logic [ConfigBit-1:0] offset_cnt;
  logic                 en_filter;
  logic                 clear;

  // Datapath / downstream
  logic                 mac_en;
  logic                 psum_valid;
  logic                 psum_last;
  logic                 win_advance;
  logic                 busy;
  logic                 cfg_err;

  // Sequencer side
  modport master (
    input  start, cfg_fsize, cfg_nfilt, cfg_nwin, ifmap_valid, psum_ready,
    output filter_size, offset_cnt, en_filter, clear, mac_en, psum_valid, psum_last,
           win_advance, busy, cfg_err
  );

  // Environment side
  modport slave (
    output start, cfg_fsize, cfg_nfilt, cfg_nwin, ifmap_valid, psum_ready,
    input  filter_size, offset_cnt, en_filter, clear, mac_en, psum_valid, psum_last,
           win_advance, busy, cfg_err
  );

endinterface

// File: rtl/pe_filter_sequencer_bounded_counter.sv
// Saturating up-counter with synchronous clear and a last flag at a runtime limit.
module pe_filter_sequencer_bounded_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] cnt_o,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear wins; increments stop at the limit so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !last_o) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == limit_i);

endmodule

// File: rtl/pe_filter_sequencer.sv
// Sequences tap offsets, filter advances and window slides so every filter in the
// spad is convolved with each ifmap window, emitting one psum per filter per window.
module pe_filter_sequencer
  import pe_filter_sequencer_pkg::*;
(
  input logic                   clk,
  input logic                   rstn,
  pe_filter_sequencer_if.master bus
);

  state_e state_q, state_d;

  logic [ConfigBit-1:0] fsize_q, fsize_d;
  logic [FnumBit-1:0]   nfilt_q, nfilt_d;
  logic [WnumBit-1:0]   nwin_q, nwin_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 off_clr, off_inc, off_last;
  logic                 fidx_clr, fidx_inc, fidx_last;
  logic                 widx_clr, widx_inc, widx_last;
  logic [ConfigBit-1:0] off_cnt;
  logic [FnumBit-1:0]   fidx_cnt;
  logic [WnumBit-1:0]   widx_cnt;

  logic clear_o, en_filter_o, win_advance_o, mac_en_o, psum_valid_o, psum_last_o, busy_o;

  // Tap offset within the current filter
  pe_filter_sequencer_bounded_counter #(
    .Width (ConfigBit)
  ) u_off_cnt (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .clr_i   (off_clr),
    .inc_i   (off_inc),
    .limit_i (fsize_q - ConfigBit'(1)),
    .cnt_o   (off_cnt),
    .last_o  (off_last)
  );

  // Filter index within the current window
  pe_filter_sequencer_bounded_counter #(
    .Width (FnumBit)
  ) u_fidx_cnt (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .clr_i   (fidx_clr),
    .inc_i   (fidx_inc),
    .limit_i (nfilt_q - FnumBit'(1)),
    .cnt_o   (fidx_cnt),
    .last_o  (fidx_last)
  );

  // Window index within the job
  pe_filter_sequencer_bounded_counter #(
    .Width (WnumBit)
  ) u_widx_cnt (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .clr_i   (widx_clr),
    .inc_i   (widx_inc),
    .limit_i (nwin_q - WnumBit'(1)),
    .cnt_o   (widx_cnt),
    .last_o  (widx_last)
  );

  // Next-state, counter control and output decode
  always_comb begin
    state_d       = state_q;
    fsize_d       = fsize_q;
    nfilt_d       = nfilt_q;
    nwin_d        = nwin_q;
    cfg_err_d     = 1'b0;
    off_clr       = 1'b0;
    off_inc       = 1'b0;
    fidx_clr      = 1'b0;
    fidx_inc      = 1'b0;
    widx_clr      = 1'b0;
    widx_inc      = 1'b0;
    clear_o       = 1'b0;
    en_filter_o   = 1'b0;
    win_advance_o = 1'b0;
    mac_en_o      = 1'b0;
    psum_valid_o  = 1'b0;
    psum_last_o   = 1'b0;
    busy_o        = 1'b1;

    unique case (state_q)
      StIdle: begin
        busy_o = 1'b0;
        if (bus.start) begin
          if (cfg_valid(bus.cfg_fsize, bus.cfg_nfilt, bus.cfg_nwin)) begin
            fsize_d  = bus.cfg_fsize;
            nfilt_d  = bus.cfg_nfilt;
            nwin_d   = bus.cfg_nwin;
            off_clr  = 1'b1;
            fidx_clr = 1'b1;
            widx_clr = 1'b1;
            state_d  = StClear;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      StClear: begin
        clear_o  = 1'b1;
        off_clr  = 1'b1;
        fidx_clr = 1'b1;
        state_d  = StWaitWin;
      end

      StWaitWin: begin
        if (bus.ifmap_valid) begin
          state_d = StMac;
        end
      end

      StMac: begin
        // The counter holds at fsize-1, so the EMIT offset is the last tap.
        mac_en_o = 1'b1;
        off_inc  = 1'b1;
        if (off_last) begin
          state_d = StEmit;
        end
      end

      StEmit: begin
        psum_valid_o = 1'b1;
        psum_last_o  = fidx_last && widx_last;
        if (bus.psum_ready) begin
          off_clr = 1'b1;
          if (!fidx_last) begin
            en_filter_o = 1'b1;
            fidx_inc    = 1'b1;
            state_d     = StMac;
          end else if (!widx_last) begin
            win_advance_o = 1'b1;
            clear_o       = 1'b1;
            fidx_clr      = 1'b1;
            widx_inc      = 1'b1;
            state_d       = StWaitWin;
          end else begin
            fidx_clr = 1'b1;
            widx_clr = 1'b1;
            state_d  = StDone;
          end
        end
      end

      StDone: begin
        // One idle-looking cycle before accepting a new start.
        busy_o   = 1'b0;
        off_clr  = 1'b1;
        fidx_clr = 1'b1;
        widx_clr = 1'b1;
        state_d  = StIdle;
      end

      default: begin
        busy_o  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State, latched config and error pulse registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      fsize_q   <= '0;
      nfilt_q   <= '0;
      nwin_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fsize_q   <= fsize_d;
      nfilt_q   <= nfilt_d;
      nwin_q    <= nwin_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.filter_size = fsize_q;
  assign bus.offset_cnt  = off_cnt;
  assign bus.en_filter   = en_filter_o;
  assign bus.clear       = clear_o;
  assign bus.mac_en      = mac_en_o;
  assign bus.psum_valid  = psum_valid_o;
  assign bus.psum_last   = psum_last_o;
  assign bus.win_advance = win_advance_o;
  assign bus.busy        = busy_o;
  assign bus.cfg_err     = cfg_err_q;

  // Indices only feed the last flags; their values are not exported.
  logic unused_idx;
  assign unused_idx = ^{fidx_cnt, widx_cnt};

endmodule

// File: tb/tb_pe_filter_sequencer.sv
// Directed bench for pe_filter_sequencer with a psum scoreboard.
module tb_pe_filter_sequencer;
  import pe_filter_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rstn;

  pe_filter_sequencer_if bus ();

  pe_filter_sequencer dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 last;
    logic [ConfigBit-1:0] off;
  } psum_t;

  psum_t       exp_q[$];
  psum_t       obs_q[$];
  int          exp_rd = 0;
  int          obs_rd = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned n_en   = 0;
  int unsigned n_clr  = 0;
  int unsigned n_wa   = 0;
  int unsigned n_viol = 0;

  // Monitor: record accepted psums and pulse activity on the falling edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.psum_valid && bus.psum_ready) begin
        obs_q.push_back('{last: bus.psum_last, off: bus.offset_cnt});
      end
      n_en  <= n_en + 32'(bus.en_filter);
      n_clr <= n_clr + 32'(bus.clear);
      n_wa  <= n_wa + 32'(bus.win_advance);
      if ((bus.en_filter && (bus.clear || bus.win_advance)) ||
          (bus.win_advance && !bus.clear) ||
          (bus.cfg_err && (bus.en_filter || bus.clear || bus.win_advance))) begin
        n_viol <= n_viol + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic b, input logic c, input logic e,
                         input logic w, input logic m, input logic v, input logic l,
                         input int off);
    logic [4:0]  ov;
    logic [31:0] o;
    logic [31:0] x;
    ov = off[4:0];
    o  = {20'd0, bus.busy, bus.clear, bus.en_filter, bus.win_advance, bus.mac_en,
          bus.psum_valid, bus.psum_last, bus.offset_cnt};
    x  = {20'd0, b, c, e, w, m, v, l, ov};
    chk(tag, o, x);
  endtask

  task automatic chk_all_zero(input string tag);
    logic [31:0] o;
    o = {14'd0, bus.busy, bus.clear, bus.en_filter, bus.win_advance, bus.mac_en,
         bus.psum_valid, bus.psum_last, bus.cfg_err, bus.filter_size, bus.offset_cnt};
    chk(tag, o, 32'd0);
  endtask

  // Drive a start pulse; when expect_psums is set, queue the psums the job must emit.
  task automatic start_job(input int fs, input int nf, input int nw, input bit expect_psums);
    bus.cfg_fsize = ConfigBit'(fs);
    bus.cfg_nfilt = FnumBit'(nf);
    bus.cfg_nwin  = WnumBit'(nw);
    bus.start     = 1'b1;
    if (expect_psums) begin
      for (int i = 0; i < nf * nw; i++) begin
        exp_q.push_back('{last: (i == nf * nw - 1), off: ConfigBit'(fs - 1)});
      end
    end
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      cyc();
      n++;
    end
    chk({tag, "_done"}, 32'(n < 2000), 32'd1);
    cyc();
  endtask

  task automatic drain(input string tag);
    while (exp_rd < exp_q.size() && obs_rd < obs_q.size()) begin
      chk({tag, "_last"}, 32'(obs_q[obs_rd].last), 32'(exp_q[exp_rd].last));
      chk({tag, "_off"}, 32'(obs_q[obs_rd].off), 32'(exp_q[exp_rd].off));
      exp_rd++;
      obs_rd++;
    end
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    exp_rd = exp_q.size();
    obs_rd = obs_q.size();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    int en0, clr0, wa0, n;

    bus.start       = 1'b0;
    bus.cfg_fsize   = '0;
    bus.cfg_nfilt   = '0;
    bus.cfg_nwin    = '0;
    bus.ifmap_valid = 1'b1;
    bus.psum_ready  = 1'b1;
    rstn            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rstn = 1'b1;
    cyc();

    // fsize=3, nfilt=2, nwin=1: full cycle trace
    en0 = int'(n_en); clr0 = int'(n_clr); wa0 = int'(n_wa);
    start_job(3, 2, 1, 1'b1);
    chk_out("t1_clear", 1, 1, 0, 0, 0, 0, 0, 0); cyc();
    chk_out("t1_wait",  1, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk_out("t1_mac0",  1, 0, 0, 0, 1, 0, 0, 0); cyc();
    chk_out("t1_mac1",  1, 0, 0, 0, 1, 0, 0, 1); cyc();
    chk_out("t1_mac2",  1, 0, 0, 0, 1, 0, 0, 2); cyc();
    chk_out("t1_emit0", 1, 0, 1, 0, 0, 1, 0, 2); cyc();
    chk_out("t1_mac3",  1, 0, 0, 0, 1, 0, 0, 0); cyc();
    chk_out("t1_mac4",  1, 0, 0, 0, 1, 0, 0, 1); cyc();
    chk_out("t1_mac5",  1, 0, 0, 0, 1, 0, 0, 2); cyc();
    chk_out("t1_emit1", 1, 0, 0, 0, 0, 1, 1, 2); cyc();
    chk_out("t1_done",  0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk_out("t1_idle",  0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_fsize", 32'(bus.filter_size), 32'd3);
    drain("t1");
    chk("t1_en_cnt", 32'(int'(n_en) - en0), 32'd1);
    chk("t1_clr_cnt", 32'(int'(n_clr) - clr0), 32'd1);
    chk("t1_wa_cnt", 32'(int'(n_wa) - wa0), 32'd0);

    // fsize=1, nfilt=1, nwin=3: window slides
    en0 = int'(n_en); clr0 = int'(n_clr); wa0 = int'(n_wa);
    start_job(1, 1, 3, 1'b1);
    wait_done("t2");
    drain("t2");
    chk("t2_en_cnt", 32'(int'(n_en) - en0), 32'd0);
    chk("t2_clr_cnt", 32'(int'(n_clr) - clr0), 32'd3);
    chk("t2_wa_cnt", 32'(int'(n_wa) - wa0), 32'd2);

    // psum_ready back-pressure in EMIT
    bus.psum_ready = 1'b0;
    start_job(2, 2, 1, 1'b1);
    n = 0;
    while (bus.psum_valid !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    chk("t3_first_valid", 32'(n < 50), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk_out("t3_stall", 1, 0, 0, 0, 0, 1, 0, 1);
      cyc();
    end
    bus.psum_ready = 1'b1;
    #1;
    chk_out("t3_accept", 1, 0, 1, 0, 0, 1, 0, 1);
    cyc();
    chk_out("t3_next_mac", 1, 0, 0, 0, 1, 0, 0, 0);
    wait_done("t3");
    drain("t3");

    // ifmap_valid low for 4 cycles after CLEAR
    bus.ifmap_valid = 1'b0;
    start_job(2, 1, 1, 1'b1);
    chk_out("t4_clear", 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_out("t4_wait", 1, 0, 0, 0, 0, 0, 0, 0);
    end
    cyc();
    bus.ifmap_valid = 1'b1;
    #1;
    chk_out("t4_valid_rise", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk_out("t4_first_mac", 1, 0, 0, 0, 1, 0, 0, 0);
    wait_done("t4");
    drain("t4");

    // Rejected start, then start during MAC ignored
    bus.cfg_fsize = ConfigBit'(3);
    bus.cfg_nfilt = '0;
    bus.cfg_nwin  = WnumBit'(1);
    bus.start     = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("t5_err_pulse", {30'd0, bus.cfg_err, bus.busy}, 32'b10);
    cyc();
    chk("t5_err_clear", {30'd0, bus.cfg_err, bus.busy}, 32'b00);
    start_job(4, 1, 1, 1'b1);
    cyc();
    cyc();
    cyc();
    bus.cfg_fsize = ConfigBit'(1);
    bus.cfg_nfilt = FnumBit'(3);
    bus.start     = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_out("t5_mac_cont", 1, 0, 0, 0, 1, 0, 0, 2);
    chk("t5_fsize_kept", 32'(bus.filter_size), 32'd4);
    chk("t5_no_err", 32'(bus.cfg_err), 32'd0);
    wait_done("t5");
    drain("t5");

    // Reset mid-MAC, then a clean job
    start_job(5, 1, 1, 1'b0);
    n = 0;
    while (!(bus.mac_en === 1'b1 && bus.offset_cnt == ConfigBit'(2)) && n < 50) begin
      cyc();
      n++;
    end
    chk("t6_reach_off2", 32'(n < 50), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("t6_async_reset");
    cyc();
    cyc();
    rstn = 1'b1;
    cyc();
    chk_all_zero("t6_after_reset");
    start_job(2, 1, 2, 1'b1);
    wait_done("t6");
    drain("t6");

    chk("pulse_overlap", 32'(n_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
